seq_checker: RTL and testbench

SEQ_CHECKER -- requirements
Module: seq_checker

---
 rtl/seq_checker.sv | 242 ++++++++++++++++++++++++
 tb/tb_seq_checker.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// seq_checker: walks an external sequence memory one symbol at a time and
// compares each stored symbol against the symbol offered by a player.
// Reports pass / fail / timeout, the number of matched symbols and the
// index of the first failing symbol. All outputs come straight from flops.
module seq_checker #(
    parameter int SYM_W       = 2,
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 0,
    localparam int LEN_W      = $clog2(MAX_LEN + 1),
    localparam int ADDR_W     = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  seq_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [SYM_W-1:0]  mem_rd_data,
    input  logic              in_valid,
    input  logic [SYM_W-1:0]  in_sym,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [LEN_W-1:0]  match_cnt,
    output logic [ADDR_W-1:0] err_idx
);

    // Timeout counter is at least one bit wide so the design still elaborates
    // when the timeout is disabled.
    localparam bit              TO_EN   = (TIMEOUT_CYC > 0);
    localparam int              TO_W    = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_WAIT_IN = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [SYM_W-1:0]  r_exp;
    logic [TO_W-1:0]   r_to_cnt;
    logic [LEN_W-1:0]  r_match_cnt;
    logic [ADDR_W-1:0] r_err_idx;
    logic              r_pass;
    logic              r_fail;
    logic              r_timeout;
    logic              r_done;
    logic              r_busy;
    logic              r_in_ready;
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;

    logic [LEN_W-1:0]  w_len_nxt;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [SYM_W-1:0]  w_exp_nxt;
    logic [TO_W-1:0]   w_to_nxt;
    logic [LEN_W-1:0]  w_match_nxt;
    logic [ADDR_W-1:0] w_err_nxt;
    logic              w_pass_nxt;
    logic              w_fail_nxt;
    logic              w_timeout_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic              w_in_ready_nxt;
    logic              w_mem_rd_en_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;

    logic [LEN_W-1:0]  w_len_clamp;
    logic [LEN_W-1:0]  w_match_inc;
    logic [ADDR_W-1:0] w_idx_inc;
    logic              w_xfer;
    logic              w_sym_ok;

    // Requested run length is clamped to the memory depth.
    assign w_len_clamp = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
    assign w_match_inc = r_match_cnt + LEN_W'(1);
    assign w_idx_inc   = r_idx + ADDR_W'(1);
    // in_ready is a flop that is high exactly while waiting for the player.
    assign w_xfer      = r_in_ready & in_valid;
    assign w_sym_ok    = (in_sym == r_exp);

    // Next-state and next-value logic for the run controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_idx_nxt     = r_idx;
        w_exp_nxt     = r_exp;
        w_to_nxt      = r_to_cnt;
        w_match_nxt   = r_match_cnt;
        w_err_nxt     = r_err_idx;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_timeout_nxt = r_timeout;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_pass_nxt    = 1'b0;
                    w_fail_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_match_nxt   = '0;
                    w_err_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_len_nxt     = w_len_clamp;
                    if (w_len_clamp == LEN_W'(0)) begin
                        // Empty run completes immediately without touching memory.
                        w_state_nxt = S_DONE;
                        w_pass_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                end else begin
                    w_exp_nxt   = mem_rd_data;
                    w_to_nxt    = '0;
                    w_state_nxt = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (abort) begin
                    // Abort wins over a same-cycle transfer or timeout.
                    w_state_nxt = S_IDLE;
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                end else if (w_xfer && w_sym_ok) begin
                    w_match_nxt = w_match_inc;
                    w_idx_nxt   = w_idx_inc;
                    if (w_match_inc == r_len) begin
                        w_state_nxt = S_DONE;
                        w_pass_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else if (w_xfer) begin
                    w_state_nxt = S_DONE;
                    w_fail_nxt  = 1'b1;
                    w_err_nxt   = r_idx;
                    w_done_nxt  = 1'b1;
                end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
                    // This is the last idle cycle allowed for the symbol.
                    w_state_nxt   = S_DONE;
                    w_fail_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_err_nxt     = r_idx;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so they align with it.
    assign w_busy_nxt      = (w_state_nxt == S_FETCH) || (w_state_nxt == S_LOAD) ||
                             (w_state_nxt == S_WAIT_IN);
    assign w_in_ready_nxt  = (w_state_nxt == S_WAIT_IN);
    assign w_mem_rd_en_nxt = (w_state_nxt == S_FETCH);
    assign w_mem_addr_nxt  = w_mem_rd_en_nxt ? w_idx_nxt : r_mem_addr;

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_exp       <= '0;
            r_to_cnt    <= '0;
            r_match_cnt <= '0;
            r_err_idx   <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_exp       <= w_exp_nxt;
            r_to_cnt    <= w_to_nxt;
            r_match_cnt <= w_match_nxt;
            r_err_idx   <= w_err_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_timeout   <= w_timeout_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_mem_rd_en <= w_mem_rd_en_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
        end
    end

    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign timeout   = r_timeout;
    assign match_cnt = r_match_cnt;
    assign err_idx   = r_err_idx;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: directed scenarios with literal expectations plus
// randomized runs, all checked each cycle against a run-level model.
module tb_seq_checker;

    localparam int SYM_W       = 2;
    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 5;
    localparam int LEN_W       = 5;
    localparam int ADDR_W      = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [LEN_W-1:0]  seq_len = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [SYM_W-1:0]  mem_rd_data = '0;
    logic              in_valid = 1'b0;
    logic [SYM_W-1:0]  in_sym = '0;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [LEN_W-1:0]  match_cnt;
    logic [ADDR_W-1:0] err_idx;

    seq_checker #(
        .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seq_len(seq_len), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .in_valid(in_valid), .in_sym(in_sym),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .match_cnt(match_cnt), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    // External sequence memory: registered read, data valid the cycle after the strobe.
    logic [SYM_W-1:0] mem [MAX_LEN];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level model: a run is "busy" with a countdown to the next symbol
    // request (2 = memory read cycle, 0 = waiting for the player).
    bit m_busy, m_pass, m_fail, m_tmo, m_done;
    int m_wait, m_idx, m_len, m_match, m_err, m_idle;

    task automatic model_finish(input bit ok, input bit tmo);
        m_busy = 1'b0;
        m_done = 1'b1;
        m_pass = ok;
        m_fail = !ok;
        m_tmo  = tmo;
        if (!ok) m_err = m_idx;
    endtask

    // Advance the model by the clock edge that just passed (inputs are still
    // the ones sampled there).
    task automatic model_step();
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
            m_wait = 0; m_idx = 0; m_len = 0; m_match = 0; m_err = 0; m_idle = 0;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 0; m_pass = 0; m_fail = 0;
            end else if (m_wait > 0) begin
                m_wait--;
                m_idle = 0;
            end else if (in_valid) begin
                if (in_sym == mem[m_idx % MAX_LEN]) begin
                    m_match++;
                    m_idx++;
                    if (m_match == m_len) model_finish(1'b1, 1'b0);
                    else m_wait = 2;
                end else begin
                    model_finish(1'b0, 1'b0);
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) model_finish(1'b0, 1'b1);
            end
        end else if (start) begin
            m_pass = 0; m_fail = 0; m_tmo = 0; m_match = 0; m_err = 0; m_idx = 0;
            m_len = (int'(seq_len) > MAX_LEN) ? MAX_LEN : int'(seq_len);
            if (m_len == 0) begin
                m_pass = 1; m_done = 1;
            end else begin
                m_busy = 1; m_wait = 2; m_idle = 0;
            end
        end
    endtask

    // Compare process: every falling edge, step the model and check all outputs.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("busy", busy, m_busy);
            chk("in_ready", in_ready, m_busy && m_wait == 0);
            chk("mem_rd_en", mem_rd_en, m_busy && m_wait == 2);
            if (m_busy && m_wait == 2) chk("mem_addr", mem_addr, m_idx);
            chk("done", done, m_done);
            chk("pass", pass, m_pass);
            chk("fail", fail, m_fail);
            chk("timeout", timeout, m_tmo);
            chk("match_cnt", match_cnt, m_match);
            chk("err_idx", err_idx, m_err);
        end
    end

    // Drive point: just after the falling edge, away from both edges.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input int len);
        start = 1'b1;
        seq_len = LEN_W'(len);
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL wait_ready: in_ready low for %0d cycles, expected high", n);
        end
    endtask

    task automatic send(input logic [SYM_W-1:0] s);
        in_valid = 1'b1;
        in_sym = s;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic play(input int first, input int last);
        int n;
        for (int i = first; i <= last; i++) begin
            wait_ready(n);
            send(mem[i]);
        end
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int vth;
        logic [SYM_W-1:0] pat [4];
        pat[0] = 2'd1; pat[1] = 2'd3; pat[2] = 2'd0; pat[3] = 2'd2;
        for (int k = 0; k < MAX_LEN; k++) mem[k] = SYM_W'($urandom);
        for (int k = 0; k < 4; k++) mem[k] = pat[k];

        // Reset state, and no departure from IDLE without start.
        cyc(); cyc();
        chk("rst_busy", busy, 0);
        chk("rst_match", match_cnt, 0);
        chk("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_no_start", busy, 0);

        // Full match of {1,3,0,2}.
        start_run(4);
        chk("fetch0_rd", mem_rd_en, 1);
        chk("fetch0_addr", mem_addr, 0);
        wait_ready(n);
        chk("first_ready_lat", n + 1, 3);
        send(2'd1);
        wait_ready(n);
        chk("next_ready_lat", n + 1, 3);
        send(2'd3);
        play(2, 3);
        chk("s1_done", done, 1);
        chk("s1_pass", pass, 1);
        chk("s1_match", match_cnt, 4);
        cyc();
        chk("s1_done_pulse", done, 0);
        chk("s1_pass_held", pass, 1);

        // Mismatch at index 2.
        start_run(4);
        play(0, 1);
        wait_ready(n);
        send(2'd2);
        chk("s2_fail", fail, 1);
        chk("s2_err", err_idx, 2);
        chk("s2_match", match_cnt, 2);
        chk("s2_tmo", timeout, 0);
        chk("s2_pass", pass, 0);

        // Timeout after five idle waiting cycles.
        start_run(4);
        wait_ready(n);
        repeat (4) cyc();
        chk("s3_still_ready", in_ready, 1);
        chk("s3_not_failed", fail, 0);
        cyc();
        chk("s3_fail", fail, 1);
        chk("s3_tmo", timeout, 1);
        chk("s3_err", err_idx, 0);
        chk("s3_done", done, 1);

        // Transfer on the fifth idle cycle is a normal compare.
        start_run(4);
        wait_ready(n);
        repeat (4) cyc();
        send(2'd1);
        chk("s3b_fail", fail, 0);
        chk("s3b_match", match_cnt, 1);
        chk("s3b_busy", busy, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("s3b_abort", busy, 0);

        // Zero-length and over-length runs.
        start_run(0);
        chk("s4_done", done, 1);
        chk("s4_pass", pass, 1);
        chk("s4_rd", mem_rd_en, 0);
        start_run(MAX_LEN + 3);
        play(0, MAX_LEN - 1);
        chk("s4_clamp_match", match_cnt, 16);
        chk("s4_clamp_pass", pass, 1);

        // Abort together with a matching transfer at index 1.
        start_run(4);
        play(0, 0);
        wait_ready(n);
        abort = 1'b1; in_valid = 1'b1; in_sym = 2'd3;
        cyc();
        abort = 1'b0; in_valid = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        chk("s5_pass", pass, 0);
        chk("s5_fail", fail, 0);
        start_run(4);
        chk("s5_restart_addr", mem_addr, 0);
        chk("s5_restart_rd", mem_rd_en, 1);
        play(0, 3);
        chk("s5_pass2", pass, 1);
        chk("s5_match2", match_cnt, 4);

        // Start ignored while busy, then reset in WAIT_IN at index 2.
        start_run(4);
        play(0, 0);
        start = 1'b1; seq_len = LEN_W'(2);
        cyc();
        start = 1'b0;
        chk("s6_start_ignored", busy, 1);
        play(1, 1);
        wait_ready(n);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_ready", in_ready, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_done", done, 0);
        chk("s6_rst_match", match_cnt, 0);
        chk("s6_rst_addr", mem_addr, 0);
        cyc();
        rst_n = 1'b1; start = 1'b1; seq_len = LEN_W'(4);
        cyc();
        start = 1'b0;
        chk("s6_start_after_rst", busy, 1);
        chk("s6_rd_after_rst", mem_rd_en, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        // Randomized runs.
        for (int r = 0; r < 150; r++) begin
            for (int k = 0; k < MAX_LEN; k++) mem[k] = SYM_W'($urandom);
            vth = $urandom_range(1, 3);
            start_run($urandom_range(0, 19));
            cnt = 0;
            while (m_busy && cnt < 300) begin
                in_valid = ($urandom_range(0, 3) < vth);
                in_sym = ($urandom_range(0, 15) == 0) ? SYM_W'($urandom) : mem[m_idx % MAX_LEN];
                abort = ($urandom_range(0, 99) == 0);
                start = ($urandom_range(0, 7) == 0);
                seq_len = LEN_W'($urandom_range(0, 19));
                if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
                cnt++;
            end
            in_valid = 1'b0; abort = 1'b0; start = 1'b0;
            if (cnt >= 300) begin
                total++;
                bad++;
                $display("FAIL run_bound: run %0d still busy after %0d cycles", r, cnt);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
